pc_ras: RTL and testbench

Parametrised program-counter unit for the fetch stage: holds the current fetch PC, selects the next PC from sequential, branch, jump or return sources, and keeps a small circular return-address stack (RAS) for call/return prediction. It adds a sticky halt, a configurable reset vector, a configurable width and a configurable stack depth. It sits between the hazard/control logic, which drives enable, halt and source select, and the instruction memory address port.

---
 rtl/pc_ras.sv | 112 +++++++++++
 tb/tb_pc_ras.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_ras.sv
// Fetch-stage program counter with sticky halt and a circular return-address stack.
// Next PC comes from sequential, branch, jump or RAS-pop sources and is always word-aligned.
module pc_ras #(
    parameter int unsigned          PC_W      = 32,
    parameter logic [PC_W-1:0]      RESET_PC  = '0,
    parameter int unsigned          RAS_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            WEN,
    input  logic            halt,
    input  logic [1:0]      sel,
    input  logic [PC_W-1:0] br_target,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            ras_push,
    output logic [PC_W-1:0] pco,
    output logic [PC_W-1:0] npc,
    output logic            halted,
    output logic [PC_W-1:0] ras_top,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int unsigned TP_W  = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    typedef enum logic [1:0] {
        SEL_SEQ = 2'b00,
        SEL_BR  = 2'b01,
        SEL_JMP = 2'b10,
        SEL_RET = 2'b11
    } sel_e;

    logic [PC_W-1:0]  r_pc;
    logic             r_halted;
    logic [TP_W-1:0]  r_tp;
    logic [CNT_W-1:0] r_cnt;
    logic [PC_W-1:0]  r_ras [RAS_DEPTH];

    logic             w_upd;
    logic             w_nonempty;
    logic             w_pop;
    logic             w_push;
    logic [PC_W-1:0]  w_seq;
    logic [PC_W-1:0]  w_top;
    logic [PC_W-1:0]  w_next;
    logic [TP_W-1:0]  w_tp_inc;
    logic [TP_W-1:0]  w_tp_dec;
    sel_e             w_sel;

    assign w_sel      = sel_e'(sel);
    assign w_upd      = WEN & ~halt & ~r_halted;
    assign w_nonempty = (r_cnt != '0);
    assign w_pop      = w_upd & (w_sel == SEL_RET) & w_nonempty;
    assign w_push     = w_upd & ras_push;
    assign w_seq      = r_pc + PC_W'(4);
    assign w_top      = r_ras[r_tp];
    assign w_tp_inc   = r_tp + TP_W'(1);
    assign w_tp_dec   = r_tp - TP_W'(1);

    always_comb begin
        w_next = w_seq;
        unique case (w_sel)
            SEL_SEQ: w_next = w_seq;
            SEL_BR:  w_next = br_target;
            SEL_JMP: w_next = jmp_target;
            SEL_RET: w_next = w_nonempty ? w_top : jmp_target;
            default: w_next = w_seq;
        endcase
        w_next[1:0] = 2'b00;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
            r_tp     <= '0;
            r_cnt    <= '0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else begin
            if (halt) begin
                r_halted <= 1'b1;
            end
            if (w_upd) begin
                r_pc <= w_next;
            end
            // A push that coincides with a valid pop replaces the top in place.
            if (w_push && w_pop) begin
                r_ras[r_tp] <= w_seq;
            end else if (w_push) begin
                r_tp            <= w_tp_inc;
                r_ras[w_tp_inc] <= w_seq;
                if (r_cnt != CNT_W'(RAS_DEPTH)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (w_pop) begin
                r_tp  <= w_tp_dec;
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign pco       = r_pc;
    assign npc       = w_seq;
    assign halted    = r_halted;
    assign ras_top   = w_nonempty ? w_top : '0;
    assign ras_empty = ~w_nonempty;
    assign ras_full  = (r_cnt == CNT_W'(RAS_DEPTH));

endmodule

// File: tb/tb_pc_ras.sv
// Bench for pc_ras: directed vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_pc_ras;

    logic        CLK;
    logic        RST;
    logic        WEN;
    logic        halt;
    logic [1:0]  sel;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic        ras_push;
    logic [31:0] pco, npc, ras_top;
    logic        halted, ras_empty, ras_full;

    logic [31:0] rv_pco, rv_npc, rv_top;
    logic        rv_halted, rv_empty, rv_full;

    logic        wen8;
    logic [1:0]  sel8;
    logic [7:0]  jmp8;
    logic [7:0]  pco8, npc8, top8;
    logic        halted8, empty8, full8;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    pc_ras #(.PC_W(32), .RESET_PC(32'h0), .RAS_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .WEN(WEN), .halt(halt), .sel(sel),
        .br_target(br_target), .jmp_target(jmp_target), .ras_push(ras_push),
        .pco(pco), .npc(npc), .halted(halted), .ras_top(ras_top),
        .ras_empty(ras_empty), .ras_full(ras_full)
    );

    pc_ras #(.PC_W(32), .RESET_PC(32'h400), .RAS_DEPTH(4)) u_rv (
        .CLK(CLK), .RST(RST), .WEN(WEN), .halt(halt), .sel(sel),
        .br_target(br_target), .jmp_target(jmp_target), .ras_push(ras_push),
        .pco(rv_pco), .npc(rv_npc), .halted(rv_halted), .ras_top(rv_top),
        .ras_empty(rv_empty), .ras_full(rv_full)
    );

    pc_ras #(.PC_W(8), .RESET_PC(8'h00), .RAS_DEPTH(4)) u8 (
        .CLK(CLK), .RST(RST), .WEN(wen8), .halt(1'b0), .sel(sel8),
        .br_target(8'h00), .jmp_target(jmp8), .ras_push(1'b0),
        .pco(pco8), .npc(npc8), .halted(halted8), .ras_top(top8),
        .ras_empty(empty8), .ras_full(full8)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        wen;
        logic [1:0]  sel;
        logic [31:0] br;
        logic [31:0] jmp;
        logic        push;
        logic [31:0] exp_pc;
        logic [31:0] exp_top;
        logic        exp_empty;
        logic        exp_full;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic [31:0] m_pc;
    logic        m_halted;
    logic [31:0] q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic async_reset();
        #3 RST = 1'b1;
        #1;
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        m_halted = 1'b0;
        q.delete();
    endtask

    task automatic model_step();
        logic        upd;
        logic [31:0] seq, nxt;
        logic        pop_ok;
        upd = WEN && !halt && !m_halted;
        if (halt) m_halted = 1'b1;
        if (upd) begin
            seq = m_pc + 32'd4;
            pop_ok = (sel == 2'd3) && (q.size() > 0);
            case (sel)
                2'd0: nxt = seq;
                2'd1: nxt = br_target;
                2'd2: nxt = jmp_target;
                default: nxt = pop_ok ? q[q.size()-1] : jmp_target;
            endcase
            if (ras_push && pop_ok) q[q.size()-1] = seq;
            else if (ras_push) begin
                q.push_back(seq);
                if (q.size() > 4) void'(q.pop_front());
            end else if (pop_ok) void'(q.pop_back());
            m_pc = nxt & 32'hFFFF_FFFC;
        end
    endtask

    task automatic model_check();
        chk("rnd_pco", pco, m_pc);
        chk("rnd_npc", npc, m_pc + 32'd4);
        chk("rnd_halted", {31'b0, halted}, {31'b0, m_halted});
        chk("rnd_top", ras_top, (q.size() > 0) ? q[q.size()-1] : 32'h0);
        chk("rnd_empty", {31'b0, ras_empty}, {31'b0, q.size() == 0});
        chk("rnd_full", {31'b0, ras_full}, {31'b0, q.size() == 4});
    endtask

    task automatic drive(input logic w, input logic h, input logic [1:0] s,
                         input logic [31:0] b, input logic [31:0] j, input logic p);
        WEN = w; halt = h; sel = s; br_target = b; jmp_target = j; ras_push = p;
    endtask

    initial begin
        RST = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
        wen8 = 1'b0; sel8 = 2'd0; jmp8 = 8'h0;

        vecs.push_back('{1'b1, 2'd0, 32'h0,   32'h0,   1'b0, 32'h4,   32'h0,  1'b1, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 32'h0,   32'h0,   1'b0, 32'h8,   32'h0,  1'b1, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 32'h0,   32'h0,   1'b0, 32'hC,   32'h0,  1'b1, 1'b0});
        vecs.push_back('{1'b1, 2'd1, 32'h100, 32'h0,   1'b0, 32'h100, 32'h0,  1'b1, 1'b0});
        vecs.push_back('{1'b0, 2'd1, 32'h200, 32'h0,   1'b0, 32'h100, 32'h0,  1'b1, 1'b0});
        vecs.push_back('{1'b1, 2'd1, 32'h200, 32'h0,   1'b0, 32'h200, 32'h0,  1'b1, 1'b0});
        vecs.push_back('{1'b1, 2'd1, 32'h203, 32'h0,   1'b0, 32'h200, 32'h0,  1'b1, 1'b0});
        vecs.push_back('{1'b1, 2'd2, 32'h0,   32'h10,  1'b0, 32'h10,  32'h0,  1'b1, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 32'h0,   32'h0,   1'b1, 32'h14,  32'h14, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 32'h0,   32'h0,   1'b1, 32'h18,  32'h18, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 32'h0,   32'h0,   1'b1, 32'h1C,  32'h1C, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 32'h0,   32'h0,   1'b1, 32'h20,  32'h20, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 2'd0, 32'h0,   32'h0,   1'b1, 32'h24,  32'h24, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 2'd3, 32'h0,   32'h500, 1'b0, 32'h24,  32'h20, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 2'd3, 32'h0,   32'h500, 1'b0, 32'h20,  32'h1C, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 2'd3, 32'h0,   32'h500, 1'b0, 32'h1C,  32'h18, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 2'd3, 32'h0,   32'h500, 1'b0, 32'h18,  32'h0,  1'b1, 1'b0});
        vecs.push_back('{1'b1, 2'd3, 32'h0,   32'h500, 1'b0, 32'h500, 32'h0,  1'b1, 1'b0});
        vecs.push_back('{1'b1, 2'd2, 32'h0,   32'h4C,  1'b0, 32'h4C,  32'h0,  1'b1, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 32'h0,   32'h0,   1'b1, 32'h50,  32'h50, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 2'd2, 32'h0,   32'h80,  1'b0, 32'h80,  32'h50, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 2'd3, 32'h0,   32'h999, 1'b1, 32'h50,  32'h84, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 2'd3, 32'h0,   32'h999, 1'b0, 32'h84,  32'h0,  1'b1, 1'b0});
        vecs.push_back('{1'b1, 2'd3, 32'h0,   32'h600, 1'b1, 32'h600, 32'h88, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 32'h0,   32'h0,   1'b1, 32'h600, 32'h88, 1'b0, 1'b0});

        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        chk("rst_pco", pco, 32'h0);
        chk("rst_npc", npc, 32'h4);
        chk("rst_top", ras_top, 32'h0);
        chk("rst_empty", {31'b0, ras_empty}, 32'h1);
        chk("rst_full", {31'b0, ras_full}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_vec_pco", rv_pco, 32'h400);

        foreach (vecs[i]) begin
            drive(vecs[i].wen, 1'b0, vecs[i].sel, vecs[i].br, vecs[i].jmp, vecs[i].push);
            step();
            chk($sformatf("vec%0d_pco", i), pco, vecs[i].exp_pc);
            chk($sformatf("vec%0d_npc", i), npc, vecs[i].exp_pc + 32'd4);
            chk($sformatf("vec%0d_top", i), ras_top, vecs[i].exp_top);
            chk($sformatf("vec%0d_empty", i), {31'b0, ras_empty}, {31'b0, vecs[i].exp_empty});
            chk($sformatf("vec%0d_full", i), {31'b0, ras_full}, {31'b0, vecs[i].exp_full});
            if (i < 3) chk($sformatf("vec%0d_rv_pco", i), rv_pco, 32'h400 + 32'(4 * (i + 1)));
        end

        // Fill the stack, then reset between edges
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
            step();
        end
        chk("fill_full", {31'b0, ras_full}, 32'h1);
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
        async_reset();
        chk("async_empty", {31'b0, ras_empty}, 32'h1);
        chk("async_full", {31'b0, ras_full}, 32'h0);
        chk("async_top", ras_top, 32'h0);
        chk("async_pco", pco, 32'h0);
        RST = 1'b0;
        step();

        // 8-bit PC wrap
        wen8 = 1'b1; sel8 = 2'd2; jmp8 = 8'hFC;
        step();
        chk("w8_pco_fc", {24'b0, pco8}, 32'hFC);
        chk("w8_npc_wrap", {24'b0, npc8}, 32'h0);
        sel8 = 2'd0;
        step();
        chk("w8_pco_wrap", {24'b0, pco8}, 32'h0);
        wen8 = 1'b0;

        // Sticky halt
        drive(1'b1, 1'b0, 2'd2, 32'h0, 32'h30, 1'b0);
        step();
        chk("halt_pre_pco", pco, 32'h30);
        drive(1'b0, 1'b1, 2'd1, 32'h700, 32'h0, 1'b1);
        step();
        chk("halt_set", {31'b0, halted}, 32'h1);
        chk("halt_pco", pco, 32'h30);
        for (int k = 0; k < 10; k++) begin
            drive(1'($urandom), 1'b0, 2'($urandom), $urandom, $urandom, 1'($urandom));
            step();
            chk($sformatf("halt_hold%0d_pco", k), pco, 32'h30);
            chk($sformatf("halt_hold%0d_flag", k), {31'b0, halted}, 32'h1);
            chk($sformatf("halt_hold%0d_empty", k), {31'b0, ras_empty}, 32'h1);
        end
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
        async_reset();
        chk("halt_rst_pco", pco, 32'h0);
        chk("halt_rst_flag", {31'b0, halted}, 32'h0);
        RST = 1'b0;
        step();

        // Randomized run against the reference model
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            if (m_halted && ($urandom_range(0, 3) == 0)) begin
                RST = 1'b1;
                #1 RST = 1'b0;
                model_reset();
                model_check();
            end
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 99) == 0), 2'($urandom),
                  $urandom, $urandom, 1'($urandom));
            model_step();
            step();
            model_check();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
